// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/ALU/select encodings and the per-stage control bundles of the control pipeline.
package ctrl_pkg;
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_PC   = 2'b10;
  localparam logic [1:0] WSEL_SETX = 2'b11;
  localparam logic [1:0] JP_NONE = 2'b00;
  localparam logic [1:0] JP_J    = 2'b01;
  localparam logic [1:0] JP_JR   = 2'b10;
  localparam logic [1:0] JP_BEX  = 2'b11;
  typedef struct packed {
    logic       valid;
    logic [4:0] aluop;
    logic       alu_inb;
    logic       br;
    logic [1:0] jp;
    logic       md;
    logic       lw;
    logic       dmwe;
    logic       rwe;
    logic [1:0] wsel;
    logic [4:0] rd;
  } ctrl_bundle_t;
  typedef struct packed {
    logic       valid;
    logic       dmwe;
    logic       rwe;
    logic [1:0] wsel;
    logic [4:0] rd;
  } mem_bundle_t;
  typedef struct packed {
    logic       valid;
    logic       rwe;
    logic [1:0] wsel;
    logic [4:0] rd;
  } wb_bundle_t;
  function automatic logic is_md(input logic [4:0] aluop);
    return aluop == ALU_MUL || aluop == ALU_DIV;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction -> control bundle plus the registers it reads.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter logic [4:0] RA_REG     = 5'd31,
  parameter logic [4:0] STATUS_REG = 5'd30,
  parameter bit         MD_EN      = 1'b1
)(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         ra_en,
  output logic [4:0]   ra,
  output logic         rb_en,
  output logic [4:0]   rb
);
  logic [4:0] op, rd_f, rs, rt, wr;
  logic is_r, is_j, is_bne, is_jal, is_jr, is_addi, is_blt, is_sw, is_lw, is_setx, is_bex;
  assign op      = instr[31:27];
  assign rd_f    = instr[26:22];
  assign rs      = instr[21:17];
  assign rt      = instr[16:12];
  assign is_r    = op == OP_R;
  assign is_j    = op == OP_J;
  assign is_bne  = op == OP_BNE;
  assign is_jal  = op == OP_JAL;
  assign is_jr   = op == OP_JR;
  assign is_addi = op == OP_ADDI;
  assign is_blt  = op == OP_BLT;
  assign is_sw   = op == OP_SW;
  assign is_lw   = op == OP_LW;
  assign is_setx = op == OP_SETX;
  assign is_bex  = op == OP_BEX;
  // Non-writing instructions carry rd=0 so a zero rd alone means "no write".
  assign wr = (is_r || is_addi || is_lw) ? rd_f : is_jal ? RA_REG : is_setx ? STATUS_REG : 5'd0;
  always_comb begin
    ctrl         = '0;
    ctrl.valid   = 1'b1;
    ctrl.aluop   = is_r ? instr[6:2] : (is_bne || is_blt) ? ALU_SUB : ALU_ADD;
    ctrl.alu_inb = is_addi || is_lw || is_sw;
    ctrl.br      = is_bne || is_blt;
    ctrl.jp      = (is_j || is_jal) ? JP_J : is_jr ? JP_JR : is_bex ? JP_BEX : JP_NONE;
    ctrl.md      = MD_EN && is_r && is_md(instr[6:2]);
    ctrl.lw      = is_lw;
    ctrl.dmwe    = is_sw;
    ctrl.rwe     = wr != 5'd0;
    ctrl.wsel    = is_lw ? WSEL_MEM : is_jal ? WSEL_PC : is_setx ? WSEL_SETX : WSEL_ALU;
    ctrl.rd      = wr;
    ra_en        = is_r || is_addi || is_lw || is_sw || is_bne || is_blt || is_jr || is_bex;
    ra           = (is_sw || is_bne || is_blt || is_jr) ? rd_f : is_bex ? STATUS_REG : rs;
    rb_en        = is_r || is_sw || is_bne || is_blt;
    rb           = is_r ? rt : rs;
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: carries decoded control through X/M/W and resolves load-use,
// multdiv and redirect hazards.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int         REG_AW     = 5,
  parameter int         ALUOP_W    = 5,
  parameter logic [4:0] RA_REG     = 5'd31,
  parameter logic [4:0] STATUS_REG = 5'd30,
  parameter bit         MD_EN      = 1'b1
)(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               d_valid,
  input  logic [31:0]        d_instr,
  input  logic               x_redirect,
  input  logic               md_ready,
  output logic               stall,
  output logic               flush,
  output logic               x_valid,
  output logic [ALUOP_W-1:0] x_aluop,
  output logic               x_alu_inb,
  output logic               x_br,
  output logic [1:0]         x_jp,
  output logic               x_md_start,
  output logic               m_valid,
  output logic               m_dmwe,
  output logic               w_valid,
  output logic               w_rwe,
  output logic [1:0]         w_wsel,
  output logic [REG_AW-1:0]  w_rd
);
  typedef enum logic {IDLE, BUSY} md_state_t;
  ctrl_bundle_t dec, d_b, x_q, x_d;
  mem_bundle_t  m_q, m_d;
  wb_bundle_t   w_q, w_d;
  md_state_t    md_q, md_d;
  logic         md_start_q, md_start_d;
  logic         ra_en, rb_en, hold, load_use;
  logic [4:0]   ra, rb;
  ctrl_decode #(.RA_REG(RA_REG), .STATUS_REG(STATUS_REG), .MD_EN(MD_EN)) u_dec (
    .instr(d_instr), .ctrl(dec), .ra_en(ra_en), .ra(ra), .rb_en(rb_en), .rb(rb)
  );
  assign d_b      = d_valid ? dec : '0;
  // Redirect outranks the multdiv hold, which outranks load-use.
  assign hold     = !x_redirect && md_q == BUSY && !md_ready;
  assign load_use = x_q.valid && x_q.lw && x_q.rd != 5'd0 && d_b.valid &&
                    ((ra_en && ra == x_q.rd) || (rb_en && rb == x_q.rd));
  assign flush    = x_redirect;
  assign stall    = !x_redirect && (hold || load_use);
  always_comb begin
    x_d        = x_redirect ? '0 : hold ? x_q : load_use ? '0 : d_b;
    m_d        = hold ? '0 : '{valid: x_q.valid, dmwe: x_q.dmwe, rwe: x_q.rwe, wsel: x_q.wsel, rd: x_q.rd};
    w_d        = '{valid: m_q.valid, rwe: m_q.rwe, wsel: m_q.wsel, rd: m_q.rd};
    md_d       = x_d.md ? BUSY : IDLE;
    md_start_d = x_d.md && !hold;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q        <= '0;
      m_q        <= '0;
      w_q        <= '0;
      md_q       <= IDLE;
      md_start_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      m_q        <= m_d;
      w_q        <= w_d;
      md_q       <= md_d;
      md_start_q <= md_start_d;
    end
  end
  assign x_valid    = x_q.valid;
  assign x_aluop    = x_q.aluop;
  assign x_alu_inb  = x_q.alu_inb;
  assign x_br       = x_q.br;
  assign x_jp       = x_q.jp;
  assign x_md_start = md_start_q;
  assign m_valid    = m_q.valid;
  assign m_dmwe     = m_q.dmwe;
  assign w_valid    = w_q.valid;
  assign w_rwe      = w_q.rwe;
  assign w_wsel     = w_q.wsel;
  assign w_rd       = w_q.rd;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: table-driven, hand-sequenced and random checks against an
// instruction-level reference model of the control pipeline.
module tb_pipe_ctrl_unit;
  logic        clock = 1'b0;
  logic        reset_n, d_valid, x_redirect, md_ready;
  logic [31:0] d_instr;
  logic        stall, flush, x_valid, x_alu_inb, x_br, x_md_start, m_valid, m_dmwe, w_valid, w_rwe;
  logic [4:0]  x_aluop, w_rd;
  logic [1:0]  x_jp, w_wsel;
  logic [23:0] dut_vec;
  int          vectors = 0, miscompares = 0;

  pipe_ctrl_unit dut (
    .clock(clock), .reset_n(reset_n), .d_valid(d_valid), .d_instr(d_instr),
    .x_redirect(x_redirect), .md_ready(md_ready), .stall(stall), .flush(flush),
    .x_valid(x_valid), .x_aluop(x_aluop), .x_alu_inb(x_alu_inb), .x_br(x_br), .x_jp(x_jp),
    .x_md_start(x_md_start), .m_valid(m_valid), .m_dmwe(m_dmwe), .w_valid(w_valid),
    .w_rwe(w_rwe), .w_wsel(w_wsel), .w_rd(w_rd)
  );

  always #5 clock = ~clock;
  assign dut_vec = {stall, flush, x_valid, x_aluop, x_alu_inb, x_br, x_jp, x_md_start,
                    m_valid, m_dmwe, w_valid, w_rwe, w_wsel, w_rd};

  // Reference: one record per in-flight instruction, decoded from the ISA table.
  typedef struct packed {
    logic v; logic [4:0] aluop; logic inb, br; logic [1:0] jp; logic md, lw, dmwe, rwe;
    logic [1:0] wsel; logic [4:0] rd; logic [1:0] nrd; logic [4:0] rr0, rr1;
  } rec_t;
  rec_t mx, mm, mw;
  logic mstart;

  function automatic rec_t ref_dec(input logic [31:0] ins);
    rec_t r;
    logic [4:0] rdf, rs, rt, wr;
    r = '0; wr = 5'd0;
    rdf = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    r.v = 1'b1;
    case (ins[31:27])
      5'd0:  begin r.aluop = ins[6:2]; r.md = ins[6:2] == 5'd6 || ins[6:2] == 5'd7; wr = rdf; r.rr0 = rs; r.rr1 = rt; r.nrd = 2'd2; end
      5'd1:  r.jp = 2'd1;
      5'd2, 5'd6: begin r.aluop = 5'd1; r.br = 1'b1; r.rr0 = rdf; r.rr1 = rs; r.nrd = 2'd2; end
      5'd3:  begin r.jp = 2'd1; wr = 5'd31; r.wsel = 2'd2; end
      5'd4:  begin r.jp = 2'd2; r.rr0 = rdf; r.nrd = 2'd1; end
      5'd5:  begin r.inb = 1'b1; wr = rdf; r.rr0 = rs; r.nrd = 2'd1; end
      5'd7:  begin r.inb = 1'b1; r.dmwe = 1'b1; r.rr0 = rdf; r.rr1 = rs; r.nrd = 2'd2; end
      5'd8:  begin r.inb = 1'b1; r.lw = 1'b1; r.wsel = 2'd1; wr = rdf; r.rr0 = rs; r.nrd = 2'd1; end
      5'd21: begin wr = 5'd30; r.wsel = 2'd3; end
      5'd22: begin r.jp = 2'd3; r.rr0 = 5'd30; r.nrd = 2'd1; end
      default: ;
    endcase
    r.rwe = wr != 5'd0;
    r.rd  = wr;
    return r;
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, op);
    return {5'd0, rd, rs, rt, 5'd0, op, 2'b00};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mx = '0; mm = '0; mw = '0; mstart = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; d_valid = 1'b0; d_instr = '0; x_redirect = 1'b0; md_ready = 1'b0;
    model_clear();
    #1 chk("reset_state", {8'd0, dut_vec}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One cycle: drive D inputs, compare every output with the model, advance the model.
  task automatic step(input logic dv, input logic [31:0] ins, input logic rdr, input logic mr);
    rec_t d;
    logic hold, lu;
    logic [23:0] e;
    @(negedge clock);
    d_valid = dv; d_instr = ins; x_redirect = rdr; md_ready = mr;
    #1;
    d    = dv ? ref_dec(ins) : '0;
    hold = mx.v && mx.md && !mr;
    lu   = mx.v && mx.lw && mx.rd != 5'd0 && dv &&
           ((d.nrd >= 2'd1 && d.rr0 == mx.rd) || (d.nrd == 2'd2 && d.rr1 == mx.rd));
    e = {!rdr && (hold || lu), rdr, mx.v, mx.aluop, mx.inb, mx.br, mx.jp, mstart,
         mm.v, mm.dmwe, mw.v, mw.rwe, mw.wsel, mw.rd};
    chk("cycle_outputs", {8'd0, dut_vec}, {8'd0, e});
    mw = mm;
    if (rdr) begin mm = mx; mx = '0; mstart = 1'b0; end
    else if (hold) begin mm = '0; mstart = 1'b0; end
    else if (lu) begin mm = mx; mx = '0; mstart = 1'b0; end
    else begin mm = mx; mx = d; mstart = d.md; end
  endtask

  typedef struct {
    logic [31:0] ins; logic [4:0] aluop; logic inb, br; logic [1:0] jp;
    logic dmwe, rwe; logic [1:0] wsel; logic [4:0] rd;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int cnt, cnt2;
    logic [4:0] ops[12];
    logic [4:0] alus[5];
    tbl[0]  = '{enc_i(5'd5, 5'd1, 5'd0, 17'd5),   5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 5'd1};
    tbl[1]  = '{enc_j(5'd3, 27'd100),             5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'd2, 5'd31};
    tbl[2]  = '{enc_r(5'd0, 5'd1, 5'd2, 5'd0),     5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 5'd0};
    tbl[3]  = '{enc_r(5'd4, 5'd1, 5'd2, 5'd1),     5'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 5'd4};
    tbl[4]  = '{enc_i(5'd8, 5'd2, 5'd1, 17'd0),   5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 5'd2};
    tbl[5]  = '{enc_i(5'd7, 5'd3, 5'd1, 17'd4),   5'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 5'd0};
    tbl[6]  = '{enc_i(5'd2, 5'd1, 5'd2, 17'd3),   5'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 5'd0};
    tbl[7]  = '{enc_i(5'd6, 5'd1, 5'd2, 17'd9),   5'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 5'd0};
    tbl[8]  = '{enc_j(5'd1, 27'd50),              5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0, 5'd0};
    tbl[9]  = '{enc_i(5'd4, 5'd31, 5'd0, 17'd0),  5'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 5'd0};
    tbl[10] = '{enc_j(5'd22, 27'd77),             5'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 5'd0};
    tbl[11] = '{enc_j(5'd21, 27'd7),              5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 5'd30};
    tbl[12] = '{enc_j(5'd31, 27'h7ffffff),        5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 5'd0};
    tbl[13] = '{enc_r(5'd6, 5'd1, 5'd2, 5'd2),     5'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 5'd6};
    ops  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd31};
    alus = '{5'd0, 5'd1, 5'd2, 5'd6, 5'd7};

    do_reset();

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].ins, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk($sformatf("x_bundle[%0d]", i), {22'd0, x_valid, x_aluop, x_alu_inb, x_br, x_jp},
          {22'd0, 1'b1, tbl[i].aluop, tbl[i].inb, tbl[i].br, tbl[i].jp});
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk($sformatf("m_bundle[%0d]", i), {30'd0, m_valid, m_dmwe}, {30'd0, 1'b1, tbl[i].dmwe});
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk($sformatf("w_bundle[%0d]", i), {23'd0, w_valid, w_rwe, w_wsel, w_rd},
          {23'd0, 1'b1, tbl[i].rwe, tbl[i].wsel, tbl[i].rd});
    end

    // lw r2,0(r1) followed by add r3,r2,r4
    step(1'b1, enc_i(5'd8, 5'd2, 5'd1, 17'd0), 1'b0, 1'b0);
    step(1'b1, enc_r(5'd3, 5'd2, 5'd4, 5'd0), 1'b0, 1'b0);
    chk("load_use_stall", {31'd0, stall}, 32'd1);
    step(1'b1, enc_r(5'd3, 5'd2, 5'd4, 5'd0), 1'b0, 1'b0);
    chk("load_use_bubble", {30'd0, x_valid, stall}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0);
      if (w_valid && w_rd == 5'd3) cnt++;
    end
    chk("load_use_add_once", cnt, 1);

    // mul r5,r6,r7 with md_ready four cycles after it reaches X
    step(1'b1, enc_r(5'd5, 5'd6, 5'd7, 5'd6), 1'b0, 1'b0);
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 6; k++) begin
      step(k <= 4, enc_r(5'd8, 5'd1, 5'd1, 5'd0), 1'b0, k == 4);
      if (stall) cnt++;
      if (x_md_start) cnt2++;
    end
    chk("md_stall_cycles", cnt, 4);
    chk("md_start_pulses", cnt2, 1);
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1);

    // blt resolved taken in X: the instruction behind it is killed
    step(1'b1, enc_i(5'd6, 5'd1, 5'd2, 17'd4), 1'b0, 1'b0);
    step(1'b1, enc_i(5'd5, 5'd9, 5'd0, 17'd1), 1'b1, 1'b0);
    chk("redirect_flush", {30'd0, flush, x_br}, 32'd3);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0);
      if (x_valid) cnt++;
    end
    chk("redirect_killed", cnt, 0);

    // asynchronous reset in the middle of a multdiv hold
    step(1'b1, enc_r(5'd5, 5'd6, 5'd7, 5'd7), 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("md_hold_before_reset", {31'd0, stall}, 32'd1);
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("stall_after_reset", {31'd0, stall}, 32'd0);

    for (int n = 0; n < 800; n++) begin
      logic [4:0] op, al;
      logic [31:0] ins;
      logic mr, rdr;
      op  = ops[$urandom_range(0, 11)];
      al  = alus[$urandom_range(0, 4)];
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'd0, al, 2'b00};
      mr  = $urandom_range(0, 3) == 0;
      rdr = $urandom_range(0, 7) == 0 && !(mx.v && mx.md && !mr);
      step($urandom_range(0, 3) != 0, ins, rdr, mr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
